// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM encoding, wait-counter width and default PWM register map
package wb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    localparam int WCNT_W      = 4;
    localparam int REG_CTRL    = 0;
    localparam int REG_DIVISOR = 1;
    localparam int REG_PERIOD  = 2;
    localparam int REG_DC      = 3;
endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: maps a byte address onto a register index and flags unmapped addresses
module wb_addr_decode #(
    parameter int              ADR_W      = 16,
    parameter int              NUM_REGS   = 4,
    parameter logic [ADR_W-1:0] BASE_ADR  = '0,
    parameter int              REG_STRIDE = 2,
    parameter int              IDX_W      = 2
) (
    input  logic [ADR_W-1:0] i_adr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);
    localparam logic [ADR_W-1:0] STRIDE = ADR_W'(REG_STRIDE);
    localparam logic [ADR_W-1:0] LIMIT  = ADR_W'(NUM_REGS);
    logic [ADR_W-1:0] w_off, w_quo;
    // hit needs an in-range, stride-aligned offset at or above the base
    always_comb begin
        w_off = i_adr - BASE_ADR;
        w_quo = w_off / STRIDE;
        o_hit = (i_adr >= BASE_ADR) && ((w_off % STRIDE) == '0) && (w_quo < LIMIT);
        o_idx = w_quo[IDX_W-1:0];
    end
endmodule

// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone classic slave with byte-writable register bank, wait states and abort
module wb_reg_slave
    import wb_pkg::*;
#(
    parameter int               DATA_W      = 16,
    parameter int               ADR_W       = 16,
    parameter int               NUM_REGS    = 4,
    parameter logic [ADR_W-1:0] BASE_ADR    = '0,
    parameter int               REG_STRIDE  = 2,
    parameter int               WAIT_STATES = 0
) (
    input  logic                       i_wb_clk,
    input  logic                       i_wb_rst,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    input  logic                       i_wb_we,
    input  logic [ADR_W-1:0]           i_wb_adr,
    input  logic [DATA_W-1:0]          i_wb_data,
    input  logic [DATA_W/8-1:0]        i_wb_sel,
    output logic [DATA_W-1:0]          o_wb_data,
    output logic                       o_wb_ack,
    output logic                       o_wb_err,
    output logic [NUM_REGS*DATA_W-1:0] o_regs,
    output logic [NUM_REGS-1:0]        o_reg_wr
);
    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [WCNT_W-1:0] r_cnt;
    logic              r_we, r_hit, r_ack, r_err;
    logic [DATA_W-1:0] r_dat, r_rdata;
    logic [SEL_W-1:0]  r_sel;
    logic [IDX_W-1:0]  r_idx;
    logic [NUM_REGS-1:0] r_reg_wr;
    logic              w_req, w_live, w_dec_hit, w_hit, w_we, w_go, w_ack_d, w_err_d;
    logic [IDX_W-1:0]  w_dec_idx, w_idx;
    logic [DATA_W-1:0] w_dat, w_mask, w_rdata_d;
    logic [SEL_W-1:0]  w_sel;
    logic [NUM_REGS-1:0] w_reg_wr_d;

    assign w_req  = i_wb_cyc & i_wb_stb;
    assign w_live = (r_state == ST_IDLE);

    wb_addr_decode #(
        .ADR_W(ADR_W), .NUM_REGS(NUM_REGS), .BASE_ADR(BASE_ADR),
        .REG_STRIDE(REG_STRIDE), .IDX_W(IDX_W)
    ) u_dec (
        .i_adr(i_wb_adr), .o_hit(w_dec_hit), .o_idx(w_dec_idx)
    );

    // state register; reset drops any in-flight transfer
    always_ff @(posedge i_wb_clk) begin
        r_state <= i_wb_rst ? ST_IDLE : w_next;
    end

    // next state: RESP always falls back to IDLE so one sample yields one response
    always_comb begin
        w_next = (r_state == ST_IDLE) ? (w_req ? ((WAIT_STATES > 0) ? ST_WAIT : ST_RESP) : ST_IDLE) :
                 (r_state == ST_WAIT) ? (!i_wb_cyc ? ST_IDLE : ((r_cnt == LAST_WAIT) ? ST_RESP : ST_WAIT)) :
                 ST_IDLE;
    end

    // response decode: live bus fields on the sampling edge, captured fields afterwards
    always_comb begin
        w_hit      = w_live ? w_dec_hit : r_hit;
        w_idx      = w_live ? w_dec_idx : r_idx;
        w_we       = w_live ? i_wb_we   : r_we;
        w_dat      = w_live ? i_wb_data : r_dat;
        w_sel      = w_live ? i_wb_sel  : r_sel;
        w_go       = (w_next == ST_RESP);
        w_ack_d    = w_go & w_hit;
        w_err_d    = w_go & ~w_hit;
        w_mask     = '0;
        for (int k = 0; k < SEL_W; k++) w_mask[8*k +: 8] = {8{w_sel[k]}};
        w_reg_wr_d = '0;
        w_reg_wr_d[w_idx] = w_go & w_hit & w_we & (|w_sel);
        w_rdata_d  = (w_go & w_hit & ~w_we) ? r_regs[w_idx] : '0;
    end

    // registered outputs, request capture, wait counter and register bank
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_reg_wr <= '0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_hit    <= 1'b0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_idx    <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_ack    <= w_ack_d;
            r_err    <= w_err_d;
            r_rdata  <= w_rdata_d;
            r_reg_wr <= w_reg_wr_d;
            r_cnt    <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_live && w_req) begin
                r_we  <= i_wb_we;
                r_hit <= w_dec_hit;
                r_dat <= i_wb_data;
                r_sel <= i_wb_sel;
                r_idx <= w_dec_idx;
            end
            for (int i = 0; i < NUM_REGS; i++)
                if (w_reg_wr_d[i]) r_regs[i] <= (r_regs[i] & ~w_mask) | (w_dat & w_mask);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign o_wb_data = r_rdata;
    assign o_wb_ack  = r_ack;
    assign o_wb_err  = r_err;
    assign o_reg_wr  = r_reg_wr;
endmodule

// File: tb/tb_wb_reg_slave.sv
// tb_wb_reg_slave: directed checks of wb_reg_slave with zero and three wait states
module tb_wb_reg_slave;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
    logic [15:0] adr = '0, wdat = '0;
    logic [1:0]  sel = '0;
    logic [15:0] rd0, rd3;
    logic        ack0, ack3, err0, err3;
    logic [63:0] regs0, regs3;
    logic [3:0]  wr0, wr3;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_reg_slave #(.WAIT_STATES(0)) dut0 (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_cyc(cyc0), .i_wb_stb(stb0), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_data(rd0), .o_wb_ack(ack0),
        .o_wb_err(err0), .o_regs(regs0), .o_reg_wr(wr0)
    );

    wb_reg_slave #(.WAIT_STATES(3)) dut3 (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_cyc(cyc3), .i_wb_stb(stb3), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_data(rd3), .o_wb_ack(ack3),
        .o_wb_err(err3), .o_regs(regs3), .o_reg_wr(wr3)
    );

    // single request on the zero-wait slave; returns at the negedge of the response cycle
    task automatic start0(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        we = w; adr = a; wdat = d; sel = s; cyc0 = 1'b1; stb0 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if (regs0 !== 64'h0) begin $display("FAIL reset_regs0 got %h want 0", regs0); n_fail++; end
        n_tests++;
        if (regs3 !== 64'h0) begin $display("FAIL reset_regs3 got %h want 0", regs3); n_fail++; end
        n_tests++;
        if ({ack0, err0, wr0, rd0} !== 22'h0) begin $display("FAIL reset_outs got ack=%b err=%b wr=%b rd=%h want all 0", ack0, err0, wr0, rd0); n_fail++; end
        n_tests++;
        if ({ack3, err3} !== 2'b00) begin $display("FAIL reset_outs3 got ack=%b err=%b want 0", ack3, err3); n_fail++; end
        n_tests++;
        rst = 1'b0;
    endtask

    task automatic test_read_defaults;
        for (int i = 0; i < 4; i++) begin
            start0(1'b0, 16'(2*i), 16'h1111, 2'b11);
            if ({ack0, err0} !== 2'b10) begin $display("FAIL rd_default[%0d] ack/err got %b%b want 10", i, ack0, err0); n_fail++; end
            n_tests++;
            if (rd0 !== 16'h0000) begin $display("FAIL rd_default[%0d] data got %h want 0000", i, rd0); n_fail++; end
            n_tests++;
            cyc0 = 1'b0; stb0 = 1'b0;
            @(negedge clk);
            if ({ack0, err0} !== 2'b00) begin $display("FAIL rd_default[%0d] pulse got %b%b want 00", i, ack0, err0); n_fail++; end
            n_tests++;
        end
    endtask

    task automatic test_write_full;
        start0(1'b1, 16'h4, 16'hA5C3, 2'b11);
        if ({ack0, err0} !== 2'b10) begin $display("FAIL wr_full ack/err got %b%b want 10", ack0, err0); n_fail++; end
        n_tests++;
        if (wr0 !== 4'b0100) begin $display("FAIL wr_full strobe got %b want 0100", wr0); n_fail++; end
        n_tests++;
        if (regs0[47:32] !== 16'hA5C3) begin $display("FAIL wr_full reg2 got %h want a5c3", regs0[47:32]); n_fail++; end
        n_tests++;
        cyc0 = 1'b0; stb0 = 1'b0;
        @(negedge clk);
        if (wr0 !== 4'b0000) begin $display("FAIL wr_full strobe_len got %b want 0000", wr0); n_fail++; end
        n_tests++;
        start0(1'b0, 16'h4, 16'h0, 2'b00);
        if (rd0 !== 16'hA5C3) begin $display("FAIL wr_full readback got %h want a5c3", rd0); n_fail++; end
        n_tests++;
        cyc0 = 1'b0; stb0 = 1'b0;
    endtask

    task automatic test_byte_lanes;
        start0(1'b1, 16'h4, 16'hFFFF, 2'b01);
        if (regs0[47:32] !== 16'hA5FF) begin $display("FAIL lane_lo reg2 got %h want a5ff", regs0[47:32]); n_fail++; end
        n_tests++;
        if (wr0 !== 4'b0100) begin $display("FAIL lane_lo strobe got %b want 0100", wr0); n_fail++; end
        n_tests++;
        cyc0 = 1'b0; stb0 = 1'b0;
        start0(1'b1, 16'h4, 16'h0000, 2'b00);
        if (ack0 !== 1'b1) begin $display("FAIL lane_none ack got %b want 1", ack0); n_fail++; end
        n_tests++;
        if (wr0 !== 4'b0000) begin $display("FAIL lane_none strobe got %b want 0000", wr0); n_fail++; end
        n_tests++;
        if (regs0[47:32] !== 16'hA5FF) begin $display("FAIL lane_none reg2 got %h want a5ff", regs0[47:32]); n_fail++; end
        n_tests++;
        cyc0 = 1'b0; stb0 = 1'b0;
    endtask

    task automatic test_miss;
        logic [15:0] addrs [2];
        addrs = '{16'h0003, 16'h0008};
        for (int a = 0; a < 2; a++) begin
            for (int w = 0; w < 2; w++) begin
                start0(1'(w), addrs[a], 16'hFFFF, 2'b11);
                if ({ack0, err0} !== 2'b01) begin $display("FAIL miss[%h,we=%0d] ack/err got %b%b want 01", addrs[a], w, ack0, err0); n_fail++; end
                n_tests++;
                if ({rd0, wr0} !== 20'h0) begin $display("FAIL miss[%h,we=%0d] data/strobe got %h/%b want 0", addrs[a], w, rd0, wr0); n_fail++; end
                n_tests++;
                if (regs0 !== 64'h0000_A5FF_0000_0000) begin $display("FAIL miss[%h,we=%0d] regs got %h want 0000a5ff00000000", addrs[a], w, regs0); n_fail++; end
                n_tests++;
                cyc0 = 1'b0; stb0 = 1'b0;
                @(negedge clk);
                if (err0 !== 1'b0) begin $display("FAIL miss[%h,we=%0d] err_len got %b want 0", addrs[a], w, err0); n_fail++; end
                n_tests++;
            end
        end
    endtask

    task automatic test_wait_states;
        @(negedge clk);
        we = 1'b1; adr = 16'h2; wdat = 16'h1234; sel = 2'b11; cyc3 = 1'b1; stb3 = 1'b1;
        @(negedge clk);
        stb3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (ack3 !== 1'(c == 4)) begin $display("FAIL wait_ack cycle %0d got %b want %b", c, ack3, c == 4); n_fail++; end
            n_tests++;
            if (c < 4) @(negedge clk);
        end
        if (regs3[31:16] !== 16'h1234) begin $display("FAIL wait_reg1 got %h want 1234", regs3[31:16]); n_fail++; end
        n_tests++;
        if (wr3 !== 4'b0010) begin $display("FAIL wait_strobe got %b want 0010", wr3); n_fail++; end
        n_tests++;
        cyc3 = 1'b0;
        @(negedge clk);
        if (ack3 !== 1'b0) begin $display("FAIL wait_ack_len got %b want 0", ack3); n_fail++; end
        n_tests++;
    endtask

    task automatic test_abort;
        @(negedge clk);
        we = 1'b1; adr = 16'h2; wdat = 16'h5555; sel = 2'b11; cyc3 = 1'b1; stb3 = 1'b1;
        @(negedge clk);
        stb3 = 1'b0;
        @(negedge clk);
        cyc3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if ({ack3, err3, wr3} !== 6'h0) begin $display("FAIL abort_resp cycle %0d got ack=%b err=%b wr=%b want 0", c, ack3, err3, wr3); n_fail++; end
            n_tests++;
        end
        if (regs3[31:16] !== 16'h1234) begin $display("FAIL abort_reg1 got %h want 1234", regs3[31:16]); n_fail++; end
        n_tests++;
        we = 1'b0; cyc3 = 1'b1; stb3 = 1'b1;
        @(negedge clk);
        stb3 = 1'b0;
        repeat (3) @(negedge clk);
        if ({ack3, rd3} !== {1'b1, 16'h1234}) begin $display("FAIL abort_recover got ack=%b rd=%h want 1/1234", ack3, rd3); n_fail++; end
        n_tests++;
        cyc3 = 1'b0;
    endtask

    task automatic test_back_to_back;
        start0(1'b1, 16'h6, 16'hBEEF, 2'b11);
        cyc0 = 1'b0; stb0 = 1'b0;
        @(negedge clk);
        we = 1'b0; adr = 16'h6; cyc0 = 1'b1; stb0 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (ack0 !== 1'(c != 2)) begin $display("FAIL b2b_ack cycle %0d got %b want %b", c, ack0, c != 2); n_fail++; end
            n_tests++;
            if (rd0 !== ((c != 2) ? 16'hBEEF : 16'h0000)) begin $display("FAIL b2b_data cycle %0d got %h", c, rd0); n_fail++; end
            n_tests++;
        end
        cyc0 = 1'b0; stb0 = 1'b0;
        @(negedge clk);
        if (ack0 !== 1'b0) begin $display("FAIL b2b_tail got %b want 0", ack0); n_fail++; end
        n_tests++;
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        we = 1'b1; adr = 16'h2; wdat = 16'h7777; sel = 2'b11; cyc3 = 1'b1; stb3 = 1'b1;
        @(negedge clk);
        stb3 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if ({ack3, err3, wr3} !== 6'h0) begin $display("FAIL rst_wait_resp cycle %0d got ack=%b err=%b wr=%b want 0", c, ack3, err3, wr3); n_fail++; end
            n_tests++;
            @(negedge clk);
        end
        if (regs3 !== 64'h0) begin $display("FAIL rst_wait_regs3 got %h want 0", regs3); n_fail++; end
        n_tests++;
        if (regs0 !== 64'h0) begin $display("FAIL rst_wait_regs0 got %h want 0", regs0); n_fail++; end
        n_tests++;
    endtask

    initial begin
        test_reset;
        test_read_defaults;
        test_write_full;
        test_byte_lanes;
        test_miss;
        test_wait_states;
        test_abort;
        test_back_to_back;
        test_reset_in_wait;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
